// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode bundle for instr_fetch_queue.
// slave  : the queue itself (consumes fetch data and dec_take, drives decode slots).
// master : the surrounding fetch/decode logic, or a testbench standing in for it.
interface instr_fetch_queue_if #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int PC_W   = 64
);
   // Fetch side: one SRAM return per cycle, holding one or two instructions.
   logic                   fetch_valid;
   logic                   fetch_two;
   logic [PC_W-1:0]        fetch_pc;
   logic [DATA_W-1:0]      fetch_instr0;
   logic [DATA_W-1:0]      fetch_instr1;
   logic                   fetch_ready;
   logic                   flush;

   // Decode side: two oldest entries, consumed through dec_take.
   logic                   dec_valid0;
   logic                   dec_valid1;
   logic [DATA_W-1:0]      dec_instr0;
   logic [DATA_W-1:0]      dec_instr1;
   logic [PC_W-1:0]        dec_pc0;
   logic [PC_W-1:0]        dec_pc1;
   logic [1:0]             dec_take;

   // Status.
   logic [$clog2(DEPTH):0] count;
   logic                   overflow_err;

   modport slave (
      input  fetch_valid, fetch_two, fetch_pc, fetch_instr0, fetch_instr1, flush, dec_take,
      output fetch_ready, dec_valid0, dec_valid1, dec_instr0, dec_instr1,
             dec_pc0, dec_pc1, count, overflow_err
   );

   modport master (
      output fetch_valid, fetch_two, fetch_pc, fetch_instr0, fetch_instr1, flush, dec_take,
      input  fetch_ready, dec_valid0, dec_valid1, dec_instr0, dec_instr1,
             dec_pc0, dec_pc1, count, overflow_err
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Dual-issue instruction fetch buffer.
// Captures the instruction pair returned by the instruction SRAM each cycle,
// holds it in a DEPTH-entry circular queue of {pc, instr}, and presents the
// two oldest entries to decode. Decode consumes 0..2 per cycle via dec_take.
// fetch_ready throttles fetch so that one pair in flight plus the pair
// arriving now always fits. flush drops everything buffered and incoming.
//
// Optional macro IFB_BYPASS_EN: when the queue is empty, incoming data is
// forwarded to the decode slots in the same cycle; whatever decode takes is
// never written, the remainder is enqueued. Undefined: 1-cycle latency always.
module instr_fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int PC_W   = 64
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_queue_if.slave ifq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // One extra bit so DEPTH - count + popped never wraps.
   localparam int FW = CW + 1;

   // Storage: not reset, only pointers and count define validity.
   logic [PC_W-1:0]   pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;

   // Incoming entries in program order: e0 = (fetch_pc, instr0), e1 = (fetch_pc+4, instr1).
   logic [PC_W-1:0] fetch_pc1;
   logic            in_valid;
   logic [1:0]      in_req;
   logic            byp_active;

   logic [1:0]      q_avail;
   logic [1:0]      take_lim;
   logic [1:0]      take_eff;
   logic [1:0]      pop_n;
   logic [1:0]      skip_n;
   logic [1:0]      wr_req;
   logic [FW-1:0]   free_slots;
   logic [1:0]      push_n;
   logic            ovf_hit;

   logic            we0, we1;
   logic [AW-1:0]   waddr0, waddr1;
   logic [PC_W-1:0] wpc0;
   logic [DATA_W-1:0] winstr0;

   logic [AW-1:0]   head1_ptr;

   assign fetch_pc1 = ifq.fetch_pc + PC_W'(4);
   assign in_valid  = ifq.fetch_valid && !ifq.flush;
   assign in_req    = in_valid ? (ifq.fetch_two ? 2'd2 : 2'd1) : 2'd0;

`ifdef IFB_BYPASS_EN
   assign byp_active = in_valid && (count_q == '0);
`else
   assign byp_active = 1'b0;
`endif

   // Pop/push bookkeeping: clamp dec_take, split it between queue and bypass,
   // and trim the push to the free space, noting any overflow.
   always_comb begin
      q_avail    = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
      take_lim   = byp_active ? in_req : q_avail;
      take_eff   = (ifq.dec_take > take_lim) ? take_lim : ifq.dec_take;
      pop_n      = byp_active ? 2'd0 : take_eff;
      skip_n     = byp_active ? take_eff : 2'd0;
      wr_req     = in_req - skip_n;
      free_slots = FW'(DEPTH) - FW'(count_q) + FW'(pop_n);
      ovf_hit    = FW'(wr_req) > free_slots;
      push_n     = ovf_hit ? free_slots[1:0] : wr_req;
   end

   // Write-port steering: the first written entry is e1 when decode took e0 via bypass.
   always_comb begin
      waddr0  = wr_ptr_q;
      waddr1  = wr_ptr_q + AW'(1);
      we0     = !rst && (push_n != 2'd0);
      we1     = !rst && (push_n == 2'd2);
      wpc0    = ifq.fetch_pc;
      winstr0 = ifq.fetch_instr0;
      if (skip_n != 2'd0) begin
         wpc0    = fetch_pc1;
         winstr0 = ifq.fetch_instr1;
      end
   end

   // Next pointer/count/error state; flush overrides normal traffic.
   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      count_d  = count_q - CW'(pop_n) + CW'(push_n);
      ovf_d    = ovf_q | ovf_hit;
      if (ifq.flush) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = '0;
         ovf_d    = ovf_q;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Queue storage write ports (two per cycle, consecutive slots).
   always_ff @(posedge clk) begin
      if (we0) begin
         pc_mem_q[waddr0]    <= wpc0;
         instr_mem_q[waddr0] <= winstr0;
      end
      if (we1) begin
         pc_mem_q[waddr1]    <= fetch_pc1;
         instr_mem_q[waddr1] <= ifq.fetch_instr1;
      end
   end

   assign head1_ptr = rd_ptr_q + AW'(1);

   // Decode slots: head and head+1, or the incoming pair when bypassing.
   always_comb begin
      ifq.dec_valid0 = (count_q >= CW'(1));
      ifq.dec_valid1 = (count_q >= CW'(2));
      ifq.dec_instr0 = instr_mem_q[rd_ptr_q];
      ifq.dec_pc0    = pc_mem_q[rd_ptr_q];
      ifq.dec_instr1 = instr_mem_q[head1_ptr];
      ifq.dec_pc1    = pc_mem_q[head1_ptr];
      if (byp_active) begin
         ifq.dec_valid0 = 1'b1;
         ifq.dec_valid1 = ifq.fetch_two;
         ifq.dec_instr0 = ifq.fetch_instr0;
         ifq.dec_pc0    = ifq.fetch_pc;
         ifq.dec_instr1 = ifq.fetch_instr1;
         ifq.dec_pc1    = fetch_pc1;
      end
   end

   assign ifq.fetch_ready  = (count_q <= CW'(DEPTH - 4));
   assign ifq.count        = count_q;
   assign ifq.overflow_err = ovf_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue (DEPTH=8).
module tb_instr_fetch_queue;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 32;
   localparam int PC_W   = 64;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   instr_fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) ifq ();

   instr_fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
      .clk (clk),
      .rst (rst),
      .ifq (ifq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_instr(input logic [63:0] pc);
      mk_instr = {16'hC0DE, pc[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic two, input logic [63:0] pc,
                        input logic [1:0] take, input logic fl);
      ifq.fetch_valid  = v;
      ifq.fetch_two    = two;
      ifq.fetch_pc     = pc;
      ifq.fetch_instr0 = mk_instr(pc);
      ifq.fetch_instr1 = mk_instr(pc + 64'd4);
      ifq.dec_take     = take;
      ifq.flush        = fl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 64'd0, 2'd0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 64'h700, 2'd0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      n_checks++; if (ifq.dec_valid0 !== 1'b0) begin n_errors++; $display("FAIL reset_valid0 got %b exp 0", ifq.dec_valid0); end
      n_checks++; if (ifq.dec_valid1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid1 got %b exp 0", ifq.dec_valid1); end
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", ifq.count); end
      n_checks++; if (ifq.fetch_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", ifq.fetch_ready); end
      n_checks++; if (ifq.overflow_err !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", ifq.overflow_err); end
      step();
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL reset_idle_count got %0d exp 0", ifq.count); end
   endtask

   task automatic test_push_pop();
      do_reset();
      drive(1'b1, 1'b1, 64'h100, 2'd0, 1'b0);
      ifq.fetch_instr0 = 32'h00500093;
      ifq.fetch_instr1 = 32'h00A00113;
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd2) begin n_errors++; $display("FAIL push_count got %0d exp 2", ifq.count); end
      n_checks++; if (ifq.dec_valid0 !== 1'b1 || ifq.dec_valid1 !== 1'b1) begin n_errors++; $display("FAIL push_valid got %b%b exp 11", ifq.dec_valid0, ifq.dec_valid1); end
      n_checks++; if (ifq.dec_pc0 !== 64'h100) begin n_errors++; $display("FAIL push_pc0 got %h exp 100", ifq.dec_pc0); end
      n_checks++; if (ifq.dec_pc1 !== 64'h104) begin n_errors++; $display("FAIL push_pc1 got %h exp 104", ifq.dec_pc1); end
      n_checks++; if (ifq.dec_instr0 !== 32'h00500093) begin n_errors++; $display("FAIL push_instr0 got %h exp 00500093", ifq.dec_instr0); end
      n_checks++; if (ifq.dec_instr1 !== 32'h00A00113) begin n_errors++; $display("FAIL push_instr1 got %h exp 00a00113", ifq.dec_instr1); end
      ifq.dec_take = 2'd1;
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd1) begin n_errors++; $display("FAIL pop1_count got %0d exp 1", ifq.count); end
      n_checks++; if (ifq.dec_pc0 !== 64'h104) begin n_errors++; $display("FAIL pop1_pc0 got %h exp 104", ifq.dec_pc0); end
      n_checks++; if (ifq.dec_instr0 !== 32'h00A00113) begin n_errors++; $display("FAIL pop1_instr0 got %h exp 00a00113", ifq.dec_instr0); end
      n_checks++; if (ifq.dec_valid1 !== 1'b0) begin n_errors++; $display("FAIL pop1_valid1 got %b exp 0", ifq.dec_valid1); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 64'h100 + 64'(8 * i), 2'd0, 1'b0);
         step();
         idle();
         n_checks++; if (ifq.count !== 4'(2 * (i + 1))) begin n_errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, ifq.count, 2 * (i + 1)); end
         n_checks++; if (ifq.fetch_ready !== ((2 * (i + 1)) <= 4)) begin n_errors++; $display("FAIL fill_ready[%0d] got %b exp %b", i, ifq.fetch_ready, (2 * (i + 1)) <= 4); end
      end
      n_checks++; if (ifq.overflow_err !== 1'b0) begin n_errors++; $display("FAIL full_no_ovf got %b exp 0", ifq.overflow_err); end
      drive(1'b1, 1'b1, 64'h120, 2'd0, 1'b0);
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd8) begin n_errors++; $display("FAIL ovf_count got %0d exp 8", ifq.count); end
      n_checks++; if (ifq.overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b exp 1", ifq.overflow_err); end
      n_checks++; if (ifq.dec_pc0 !== 64'h100) begin n_errors++; $display("FAIL ovf_head got %h exp 100", ifq.dec_pc0); end
      ifq.dec_take = 2'd2;
      step();
      idle();
      n_checks++; if (ifq.overflow_err !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b exp 1", ifq.overflow_err); end
   endtask

   task automatic test_full_wrap();
      logic [63:0] exp_pc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 64'h100 + 64'(8 * i), 2'd0, 1'b0);
         step();
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b1, 64'h120 + 64'(8 * k), 2'd2, 1'b0);
         exp_pc = 64'h100 + 64'(8 * k);
         n_checks++; if (ifq.dec_pc0 !== exp_pc || ifq.dec_pc1 !== exp_pc + 64'd4) begin n_errors++; $display("FAIL wrap_head[%0d] got %h/%h exp %h", k, ifq.dec_pc0, ifq.dec_pc1, exp_pc); end
         step();
         idle();
         n_checks++; if (ifq.count !== 4'd8) begin n_errors++; $display("FAIL wrap_count[%0d] got %0d exp 8", k, ifq.count); end
      end
      for (int j = 0; j < 4; j++) begin
         exp_pc = 64'h130 + 64'(8 * j);
         ifq.dec_take = 2'd2;
         n_checks++; if (ifq.dec_pc0 !== exp_pc || ifq.dec_pc1 !== exp_pc + 64'd4) begin n_errors++; $display("FAIL drain_pc[%0d] got %h/%h exp %h", j, ifq.dec_pc0, ifq.dec_pc1, exp_pc); end
         n_checks++; if (ifq.dec_instr0 !== mk_instr(exp_pc) || ifq.dec_instr1 !== mk_instr(exp_pc + 64'd4)) begin n_errors++; $display("FAIL drain_instr[%0d] got %h/%h exp %h", j, ifq.dec_instr0, ifq.dec_instr1, mk_instr(exp_pc)); end
         step();
      end
      idle();
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL wrap_empty got %0d exp 0", ifq.count); end
      n_checks++; if (ifq.overflow_err !== 1'b0) begin n_errors++; $display("FAIL wrap_no_ovf got %b exp 0", ifq.overflow_err); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 1'b1, 64'h400, 2'd0, 1'b0); step();
      drive(1'b1, 1'b1, 64'h408, 2'd0, 1'b0); step();
      drive(1'b1, 1'b0, 64'h410, 2'd0, 1'b0); step();
      idle();
      n_checks++; if (ifq.count !== 4'd5) begin n_errors++; $display("FAIL preflush_count got %0d exp 5", ifq.count); end
      drive(1'b1, 1'b1, 64'h900, 2'd2, 1'b1);
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL flush_count got %0d exp 0", ifq.count); end
      n_checks++; if (ifq.dec_valid0 !== 1'b0 || ifq.dec_valid1 !== 1'b0) begin n_errors++; $display("FAIL flush_valid got %b%b exp 00", ifq.dec_valid0, ifq.dec_valid1); end
      drive(1'b1, 1'b1, 64'h300, 2'd0, 1'b0);
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd2) begin n_errors++; $display("FAIL postflush_count got %0d exp 2", ifq.count); end
      n_checks++; if (ifq.dec_pc0 !== 64'h300 || ifq.dec_pc1 !== 64'h304) begin n_errors++; $display("FAIL postflush_pc got %h/%h exp 300/304", ifq.dec_pc0, ifq.dec_pc1); end
   endtask

   task automatic test_illegal_take();
      do_reset();
      drive(1'b1, 1'b0, 64'h500, 2'd0, 1'b0);
      step();
      idle();
      n_checks++; if (ifq.dec_valid0 !== 1'b1 || ifq.dec_valid1 !== 1'b0) begin n_errors++; $display("FAIL single_valid got %b%b exp 10", ifq.dec_valid0, ifq.dec_valid1); end
      ifq.dec_take = 2'd2;
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL clamp2_count got %0d exp 0", ifq.count); end
      drive(1'b1, 1'b0, 64'h508, 2'd0, 1'b0);
      step();
      idle();
      ifq.dec_take = 2'd3;
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd0) begin n_errors++; $display("FAIL clamp3_count got %0d exp 0", ifq.count); end
      drive(1'b1, 1'b1, 64'h600, 2'd0, 1'b0);
      step();
      idle();
      n_checks++; if (ifq.dec_pc0 !== 64'h600 || ifq.count !== 4'd2) begin n_errors++; $display("FAIL clamp_after got pc %h cnt %0d exp 600/2", ifq.dec_pc0, ifq.count); end
   endtask

   task automatic test_bypass();
      do_reset();
      drive(1'b1, 1'b1, 64'h200, 2'd1, 1'b0);
      #1;
`ifdef IFB_BYPASS_EN
      n_checks++; if (ifq.dec_valid0 !== 1'b1 || ifq.dec_valid1 !== 1'b1) begin n_errors++; $display("FAIL byp_valid got %b%b exp 11", ifq.dec_valid0, ifq.dec_valid1); end
      n_checks++; if (ifq.dec_pc0 !== 64'h200 || ifq.dec_pc1 !== 64'h204) begin n_errors++; $display("FAIL byp_pc got %h/%h exp 200/204", ifq.dec_pc0, ifq.dec_pc1); end
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd1) begin n_errors++; $display("FAIL byp_count got %0d exp 1", ifq.count); end
      n_checks++; if (ifq.dec_pc0 !== 64'h204) begin n_errors++; $display("FAIL byp_next_pc got %h exp 204", ifq.dec_pc0); end
`else
      n_checks++; if (ifq.dec_valid0 !== 1'b0) begin n_errors++; $display("FAIL nobyp_valid got %b exp 0", ifq.dec_valid0); end
      step();
      idle();
      n_checks++; if (ifq.count !== 4'd2) begin n_errors++; $display("FAIL nobyp_count got %0d exp 2", ifq.count); end
      n_checks++; if (ifq.dec_pc0 !== 64'h200) begin n_errors++; $display("FAIL nobyp_pc got %h exp 200", ifq.dec_pc0); end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_push_pop();
      test_fill_overflow();
      test_full_wrap();
      test_flush();
      test_illegal_take();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Dual-issue instruction fetch buffer directly downstream of the 32-bit instruction SRAM.
- Captures the instruction pair returned each cycle (word at PC, word at PC+4) with its PC, and buffers it in a circular queue.
- Presents up to two in-order instructions per cycle to decode through a valid/take handshake.
- Absorbs decode stalls, throttles the fetch stage, and discards wrong-path instructions on flush.

Parameters:
- DEPTH, 8, queue entries (one instruction each); power of two, >= 4.
- DATA_W, 32, instruction width.
- PC_W, 64, program counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- fetch_valid  input  1  instruction data from SRAM valid this cycle.
- fetch_two  input  1  1 = both fetch_instr0 and fetch_instr1 valid; 0 = only fetch_instr0.
- fetch_pc  input  PC_W  PC of fetch_instr0.
- fetch_instr0  input  DATA_W  instruction at fetch_pc (SRAM rdata).
- fetch_instr1  input  DATA_W  instruction at fetch_pc+4 (SRAM rdata_nxt).
- fetch_ready  output  1  fetch stage may issue a new SRAM request this cycle.
- flush  input  1  redirect; drop all buffered and incoming instructions.
- dec_valid0  output  1  slot 0 holds a valid instruction.
- dec_valid1  output  1  slot 1 holds a valid instruction.
- dec_instr0  output  DATA_W  oldest instruction.
- dec_instr1  output  DATA_W  second-oldest instruction.
- dec_pc0  output  PC_W  PC of dec_instr0.
- dec_pc1  output  PC_W  PC of dec_instr1.
- dec_take  input  2  number of instructions consumed by decode this cycle (0, 1 or 2).
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky: a push exceeded free space.

Behaviour:
- Storage: DEPTH entries of {pc, instr}. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Entry PC for fetch_instr1 = fetch_pc + 4 (PC_W-bit add, wraps).
- Reset (rst high at posedge clk): pointers = 0, count = 0, overflow_err = 0. As a result, dec_valid0 = dec_valid1 = 0 and fetch_ready = 1. Storage contents are not reset.
- Push: when fetch_valid=1 and flush=0, write instr0, then instr1 if fetch_two=1, at consecutive write-pointer slots. Entries are visible on dec_* the next cycle (1-cycle latency).
- Pop: dec_take entries are removed from the head.
  - Legal values: dec_take <= dec_valid0 + dec_valid1.
  - An illegal dec_take is clamped to the number valid.
- Decode outputs (combinational from registered state):
  - dec_valid0 = (count >= 1); dec_valid1 = (count >= 2).
  - dec_instr0/dec_pc0 come from the head entry; dec_instr1/dec_pc1 come from head+1, modulo DEPTH.
  - When a slot is invalid, its data outputs are don't-care.
- Occupancy: count_next = count - popped + pushed. Push and pop in the same cycle are legal, including at full and at empty.
- fetch_ready = (count <= DEPTH-4), from registered count. This reserves room for one in-flight pair (SRAM read latency 1) plus the pair arriving this cycle.
- Overflow:
  - If a push needs more slots than DEPTH - count + popped, write only the slots that fit, in order, and drop the excess.
  - overflow_err is set to 1 and stays set until rst.
- Flush:
  - Highest priority. Next cycle: count = 0, read pointer = write pointer, dec_valid0/1 = 0.
  - fetch_valid in the flush cycle is discarded; dec_take in the flush cycle is ignored.
  - overflow_err is unaffected.
- rst with flush, push or pop in the same cycle: reset wins.

Optional Feature:
- Macro IFB_BYPASS_EN.
- Defined:
  - When count == 0, fetch_valid=1 and flush=0, incoming data is forwarded combinationally in the same cycle:
    - dec_valid0=1, dec_instr0=fetch_instr0, dec_pc0=fetch_pc.
    - dec_valid1=fetch_two, dec_instr1=fetch_instr1, dec_pc1=fetch_pc+4.
  - Entries taken by dec_take that cycle are not written; the remainder is enqueued.
  - Bypass applies only at count == 0.
- Undefined: no bypass; push-to-dec_valid latency is always 1 cycle.

Test Plan:
- Reset then idle → dec_valid0=0, dec_valid1=0, count=0, fetch_ready=1, overflow_err=0.
- Push fetch_pc=0x100, instr0=0x00500093, instr1=0x00A00113, fetch_two=1, dec_take=0 → next cycle count=2, dec_pc0=0x100, dec_pc1=0x104, both valid. Then dec_take=1 → count=1, dec_pc0=0x104.
- DEPTH=8, push four pairs with dec_take=0 → fetch_ready drops once count=6 and count ends at 8. A fifth pair → count stays 8, overflow_err=1.
- Full queue: push pair with dec_take=2 in the same cycle → count stays 8, head advances by 2, no overflow. Then run pointers around the wrap and check PC order 0x100, 0x104, ... is unbroken.
- count=5, flush=1 with fetch_valid=1 and dec_take=2 → next cycle count=0, dec_valid0=0. The discarded pair never appears.
- IFB_BYPASS_EN defined, empty queue, push pc=0x200 pair with dec_take=1 → same cycle dec_valid0=1 and dec_pc0=0x200; next cycle count=1, dec_pc0=0x204. Without the macro → same-cycle dec_valid0=0.
